// File: rtl/stack_pkg.sv
// Shared types for the operand-stack controller: FSM states and the push/pop op decode.
package stack_pkg;

  typedef enum logic {RUN, FAULT} stack_state_t;

  // Encoding matches {push, pop} so a direct cast performs the decode.
  typedef enum logic [1:0] {OP_NOP, OP_POP, OP_PUSH, OP_REPL} stack_op_t;

  function automatic stack_op_t decode_op(input logic push, input logic pop);
    return stack_op_t'({push, pop});
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Operand-stack storage: one synchronous write port, one asynchronous read port, no reset.
module stack_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_ctrl.sv
// Stack controller: stack pointer, op decode, RUN/FAULT sequencing and sticky error flags.
//   state | meaning
//   RUN   | stack traffic served normally
//   FAULT | overflow/underflow seen; all traffic blocked until clear_err
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int SP_W  = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  input  logic              flush,
  input  logic              clear_err,
  output logic [DATA_W-1:0] tos,
  output logic              tos_zero,
  output logic              empty,
  output logic              full,
  output logic [SP_W-1:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              fault
);

  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);
  localparam logic [AW-1:0]   AW_ONE  = AW'(1);

  stack_state_t      state_q, state_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [AW-1:0]     top_addr;
  logic [DATA_W-1:0] rdata;
  stack_op_t         op;

  // Modulo-DEPTH arithmetic gives DEPTH-1 when sp is full, so no extra guard is needed.
  assign top_addr = sp_q[AW-1:0] - AW_ONE;
  assign op       = decode_op(push, pop);

  assign empty     = (sp_q == '0);
  assign full      = (sp_q == SP_FULL);
  assign count     = sp_q;
  assign tos       = empty ? '0 : rdata;
  assign tos_zero  = !empty && (rdata == '0);
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign fault     = (state_q == FAULT);

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    we          = 1'b0;
    waddr       = sp_q[AW-1:0];
    if (state_q == RUN) begin
      // Clear first so a same-cycle error event below takes precedence.
      if (clear_err) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end
      if (flush) begin
        sp_d = '0;
      end else begin
        unique case (op)
          OP_PUSH: begin
            if (full) begin
              overflow_d = 1'b1;
              state_d    = FAULT;
            end else begin
              we   = 1'b1;
              sp_d = sp_q + SP_ONE;
            end
          end
          OP_POP: begin
            if (empty) begin
              underflow_d = 1'b1;
              state_d     = FAULT;
            end else begin
              sp_d = sp_q - SP_ONE;
            end
          end
          OP_REPL: begin
            we = 1'b1;
            if (empty) begin
              sp_d        = SP_ONE;
              underflow_d = 1'b1;
              state_d     = FAULT;
            end else begin
              waddr = top_addr;
            end
          end
          default: ;
        endcase
      end
    end else if (clear_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      state_d     = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  stack_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(push_data),
    .raddr(top_addr),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl (DEPTH=8, DATA_W=8) with hand-computed expectations.
module tb_stack_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       push, pop, flush, clear_err;
  logic [7:0] push_data;
  logic [7:0] tos;
  logic       tos_zero, empty, full, overflow, underflow, fault;
  logic [3:0] count;

  int errors = 0;
  int checks = 0;

  stack_ctrl #(.DATA_W(8), .DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .push_data(push_data),
    .flush    (flush),
    .clear_err(clear_err),
    .tos      (tos),
    .tos_zero (tos_zero),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of controls, wait past the edge, then return to idle.
  task automatic cyc(input logic p, input logic po, input logic [7:0] d,
                     input logic f, input logic ce);
    push = p; pop = po; push_data = d; flush = f; clear_err = ce;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; push_data = 8'h00; flush = 1'b0; clear_err = 1'b0;
  endtask

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; push_data = 8'h00; flush = 1'b0; clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_tos",   32'(tos),   32'h00);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_tz",    32'(tos_zero), 32'd0);

    cyc(1, 0, 8'h11, 0, 0);
    chk("p1_tos", 32'(tos), 32'h11);
    chk("p1_tz",  32'(tos_zero), 32'd0);
    cyc(1, 0, 8'h22, 0, 0);
    chk("p2_tos", 32'(tos), 32'h22);
    chk("p2_tz",  32'(tos_zero), 32'd0);
    cyc(1, 0, 8'h00, 0, 0);
    chk("p3_tos",   32'(tos), 32'h00);
    chk("p3_tz",    32'(tos_zero), 32'd1);
    chk("p3_count", 32'(count), 32'd3);
    cyc(0, 1, 8'h00, 0, 0);
    chk("pop_tos",   32'(tos), 32'h22);
    chk("pop_tz",    32'(tos_zero), 32'd0);
    chk("pop_count", 32'(count), 32'd2);

    cyc(0, 0, 8'h00, 1, 0);
    chk("flush_count", 32'(count), 32'd0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'hA0 + 8'(i), 0, 0);
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_tos",   32'(tos),   32'hA7);
    cyc(1, 0, 8'hFF, 0, 0);
    chk("ovf_count", 32'(count),    32'd8);
    chk("ovf_tos",   32'(tos),      32'hA7);
    chk("ovf_flag",  32'(overflow), 32'd1);
    chk("ovf_fault", 32'(fault),    32'd1);
    cyc(1, 0, 8'h55, 0, 0);
    chk("fpush_count", 32'(count), 32'd8);
    chk("fpush_tos",   32'(tos),   32'hA7);
    cyc(0, 1, 8'h00, 1, 0);
    chk("fpopflush_count", 32'(count), 32'd8);
    chk("fpopflush_fault", 32'(fault), 32'd1);
    cyc(0, 0, 8'h00, 0, 1);
    chk("clr_fault", 32'(fault),    32'd0);
    chk("clr_ovf",   32'(overflow), 32'd0);

    cyc(0, 0, 8'h00, 1, 0);
    cyc(1, 0, 8'h05, 0, 0);
    cyc(1, 0, 8'h07, 0, 0);
    cyc(1, 1, 8'h0C, 0, 0);
    chk("repl_count", 32'(count), 32'd2);
    chk("repl_tos",   32'(tos),   32'h0C);
    chk("repl_fault", 32'(fault), 32'd0);
    cyc(0, 1, 8'h00, 0, 0);
    chk("repl_pop_tos",   32'(tos),   32'h05);
    chk("repl_pop_count", 32'(count), 32'd1);

    cyc(0, 0, 8'h00, 1, 0);
    cyc(1, 1, 8'h3A, 0, 0);
    chk("erepl_count", 32'(count),     32'd1);
    chk("erepl_tos",   32'(tos),       32'h3A);
    chk("erepl_unf",   32'(underflow), 32'd1);
    chk("erepl_fault", 32'(fault),     32'd1);
    chk("erepl_ovf",   32'(overflow),  32'd0);
    cyc(0, 0, 8'h00, 0, 1);
    chk("eclr_unf",   32'(underflow), 32'd0);
    chk("eclr_fault", 32'(fault),     32'd0);
    chk("eclr_count", 32'(count),     32'd1);
    cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 1, 8'h00, 0, 0);
    chk("upop_unf",   32'(underflow), 32'd1);
    chk("upop_fault", 32'(fault),     32'd1);
    chk("upop_count", 32'(count),     32'd0);
    cyc(0, 0, 8'h00, 0, 1);
    chk("upop_clr", 32'(underflow), 32'd0);

    for (int i = 1; i <= 4; i++) cyc(1, 0, 8'(i), 0, 0);
    chk("fp_pre_count", 32'(count), 32'd4);
    cyc(1, 0, 8'h99, 1, 0);
    chk("fp_count", 32'(count), 32'd0);
    chk("fp_empty", 32'(empty), 32'd1);
    chk("fp_tos",   32'(tos),   32'h00);

    for (int i = 0; i < 8; i++) cyc(1, 0, 8'h60 + 8'(i), 0, 0);
    cyc(1, 0, 8'hEE, 0, 1);
    chk("ceovf_flag",  32'(overflow), 32'd1);
    chk("ceovf_fault", 32'(fault),    32'd1);
    chk("ceovf_tos",   32'(tos),      32'h67);
    cyc(0, 0, 8'h00, 0, 1);
    chk("ceovf_clr", 32'(overflow), 32'd0);

    cyc(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'h30 + 8'(i), 0, 0);
    chk("mid_pre_count", 32'(count), 32'd5);
    chk("mid_pre_tos",   32'(tos),   32'h34);
    #1 reset = 1'b0;
    #1;
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_tos",   32'(tos),   32'h00);
    @(posedge clk); #1 reset = 1'b1;
    cyc(1, 0, 8'h42, 0, 0);
    chk("post_tos",   32'(tos),   32'h42);
    chk("post_count", 32'(count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
